// File: rtl/invader_missiles.sv
// Enemy missile launcher: N_MSL independent slots that drop from the lowest
// live invader of a pseudo-randomly chosen column, advance once per frame and cool down after retiring.
module invader_missiles #(
   parameter int          N_MSL     = 3,
   parameter int          INV_COLS  = 11,
   parameter int          INV_ROWS  = 5,
   parameter int          STEP      = 4,
   parameter int          FLOOR_Y   = 464,
   parameter int          COL_PITCH = 32,
   parameter int          ROW_PITCH = 32,
   parameter int          SPR_W     = 24,
   parameter int          SPR_H     = 16,
   parameter int          COOLDOWN  = 8,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         frame,
   input  logic                         enable,
   input  logic [9:0]                   inv_x,
   input  logic [9:0]                   inv_y,
   input  logic [INV_COLS*INV_ROWS-1:0] alive,
   input  logic                         hit_valid,
   input  logic [2:0]                   hit_idx,
   output logic [N_MSL*10-1:0]          m_x,
   output logic [N_MSL*10-1:0]          m_y,
   output logic [N_MSL-1:0]             m_active,
   output logic                         fire
);

   localparam int CW  = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
   localparam int CLW = (INV_COLS < 2) ? 1 : $clog2(INV_COLS);
   localparam int RW  = (INV_ROWS < 2) ? 1 : $clog2(INV_ROWS);
   localparam logic [CW-1:0] COOL_INIT = CW'(COOLDOWN);
   localparam logic [10:0]   FLOOR_11  = 11'(FLOOR_Y);
   localparam logic [10:0]   STEP_11   = 11'(STEP);
   localparam logic [15:0]   LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {IDLE = 2'd0, FLY = 2'd1, REST = 2'd2} slot_state_t;

   logic [15:0]                         lfsr_reg;
   logic                                fire_reg;
   logic [CLW-1:0]                      col_sel;
   logic [RW-1:0]                       row_sel;
   logic                                row_found;
   logic [INV_COLS-1:0][INV_ROWS-1:0]   col_alive;
   logic [N_MSL-1:0]                    idle_vec;
   logic [N_MSL-1:0]                    launch_sel;
   logic                                launch_go;
   logic [9:0]                          launch_x;
   logic [9:0]                          launch_y;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_reg <= SEED;
         fire_reg <= 1'b0;
      end else begin
         lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);
         fire_reg <= launch_go;
      end
   end

   assign fire = fire_reg;

   // Regroup the row-major alive map so a column can be picked with one index.
   for (genvar gi = 0; gi < INV_COLS; gi++) begin : g_col
      for (genvar gj = 0; gj < INV_ROWS; gj++) begin : g_row
         assign col_alive[gi][gj] = alive[gj*INV_COLS + gi];
      end
   end

   assign col_sel = CLW'(lfsr_reg[7:0] % 8'(INV_COLS));

   always_comb begin
      row_found = 1'b0;
      row_sel   = '0;
      for (int r = 0; r < INV_ROWS; r++) begin
         if (col_alive[col_sel][r]) begin
            row_found = 1'b1;
            row_sel   = RW'(r);
         end
      end
   end

   always_comb begin
      launch_sel = '0;
      for (int k = N_MSL - 1; k >= 0; k--) begin
         if (idle_vec[k]) begin
            launch_sel    = '0;
            launch_sel[k] = 1'b1;
         end
      end
   end

   assign launch_go = frame & enable & row_found & (|idle_vec);
   assign launch_x  = inv_x + 10'(SPR_W / 2) + 10'(COL_PITCH * int'(col_sel));
   assign launch_y  = inv_y + 10'(ROW_PITCH * int'(row_sel)) + 10'(SPR_H);

   for (genvar gi = 0; gi < N_MSL; gi++) begin : g_slot
      slot_state_t   state_reg;
      logic [CW-1:0] cnt_reg;
      logic [9:0]    x_reg;
      logic [9:0]    y_reg;
      logic          active_reg;
      logic [10:0]   y_step;
      logic          hit_here;

      assign y_step   = {1'b0, y_reg} + STEP_11;
      assign hit_here = hit_valid && (hit_idx == 3'(gi));

      // Launch only from IDLE, so a slot retiring this cycle cannot relaunch.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            active_reg <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (launch_go && launch_sel[gi]) begin
                     state_reg  <= FLY;
                     x_reg      <= launch_x;
                     y_reg      <= launch_y;
                     active_reg <= 1'b1;
                  end
               end
               FLY: begin
                  if (hit_here) begin
                     state_reg  <= REST;
                     cnt_reg    <= COOL_INIT;
                     active_reg <= 1'b0;
                  end else if (frame) begin
                     if (y_step >= FLOOR_11) begin
                        state_reg  <= REST;
                        cnt_reg    <= COOL_INIT;
                        active_reg <= 1'b0;
                     end else begin
                        y_reg <= y_step[9:0];
                     end
                  end
               end
               REST: begin
                  if (frame) begin
                     if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                     end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                     end
                  end
               end
               default: begin
                  state_reg  <= IDLE;
                  active_reg <= 1'b0;
               end
            endcase
         end
      end

      assign idle_vec[gi]         = (state_reg == IDLE);
      assign m_x[10*gi +: 10]     = x_reg;
      assign m_y[10*gi +: 10]     = y_reg;
      assign m_active[gi]         = active_reg;
   end

endmodule

// File: tb/tb_invader_missiles.sv
// Directed bench for invader_missiles: a slot-level behavioural model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_invader_missiles;

   localparam int N_MSL     = 3;
   localparam int INV_COLS  = 11;
   localparam int INV_ROWS  = 5;
   localparam int STEP      = 4;
   localparam int FLOOR_Y   = 464;
   localparam int COL_PITCH = 32;
   localparam int ROW_PITCH = 32;
   localparam int SPR_W     = 24;
   localparam int SPR_H     = 16;
   localparam int COOLDOWN  = 8;
   localparam logic [15:0] SEED     = 16'hACE1;
   localparam logic [15:0] TAP_MASK = 16'hB400;   // taps 16,14,13,11

   localparam int S_IDLE = 0;
   localparam int S_FLY  = 1;
   localparam int S_REST = 2;

   logic                         clk = 1'b0;
   logic                         rst;
   logic                         frame;
   logic                         enable;
   logic [9:0]                   inv_x;
   logic [9:0]                   inv_y;
   logic [INV_COLS*INV_ROWS-1:0] alive;
   logic                         hit_valid;
   logic [2:0]                   hit_idx;
   logic [N_MSL*10-1:0]          m_x;
   logic [N_MSL*10-1:0]          m_y;
   logic [N_MSL-1:0]             m_active;
   logic                         fire;

   int n_tests = 0;
   int n_fail  = 0;
   int fire_seen = 0;
   int f0;

   invader_missiles #(
      .N_MSL(N_MSL), .INV_COLS(INV_COLS), .INV_ROWS(INV_ROWS), .STEP(STEP),
      .FLOOR_Y(FLOOR_Y), .COL_PITCH(COL_PITCH), .ROW_PITCH(ROW_PITCH),
      .SPR_W(SPR_W), .SPR_H(SPR_H), .COOLDOWN(COOLDOWN), .SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .frame(frame), .enable(enable),
      .inv_x(inv_x), .inv_y(inv_y), .alive(alive),
      .hit_valid(hit_valid), .hit_idx(hit_idx),
      .m_x(m_x), .m_y(m_y), .m_active(m_active), .fire(fire)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int          mst  [N_MSL];
   int          mcnt [N_MSL];
   int          mx   [N_MSL];
   int          my   [N_MSL];
   logic        mfire;
   logic [15:0] mlfsr;
   int          m_col;
   int          m_row;
   int          m_slot;
   logic [INV_COLS*INV_ROWS-1:0] sh;

   always_comb begin
      sh     = '0;
      m_col  = int'(mlfsr[7:0]) % INV_COLS;
      m_row  = -1;
      for (int r = 0; r < INV_ROWS; r++) begin
         sh = alive >> (r*INV_COLS + m_col);
         if (sh[0]) m_row = r;
      end
      m_slot = -1;
      for (int k = N_MSL - 1; k >= 0; k--) begin
         if (mst[k] == S_IDLE) m_slot = k;
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < N_MSL; k++) begin
            mst[k]  <= S_IDLE;
            mcnt[k] <= 0;
            mx[k]   <= 0;
            my[k]   <= 0;
         end
         mfire <= 1'b0;
         mlfsr <= SEED;
      end else begin
         mfire <= 1'b0;
         for (int k = 0; k < N_MSL; k++) begin
            if (mst[k] == S_FLY) begin
               if (hit_valid && int'(hit_idx) == k) begin
                  mst[k]  <= S_REST;
                  mcnt[k] <= COOLDOWN;
               end else if (frame) begin
                  if (my[k] + STEP >= FLOOR_Y) begin
                     mst[k]  <= S_REST;
                     mcnt[k] <= COOLDOWN;
                  end else begin
                     my[k] <= my[k] + STEP;
                  end
               end
            end else if (mst[k] == S_REST && frame) begin
               if (mcnt[k] == 0) mst[k]  <= S_IDLE;
               else              mcnt[k] <= mcnt[k] - 1;
            end
         end
         if (frame && enable && m_row >= 0 && m_slot >= 0) begin
            mst[m_slot] <= S_FLY;
            mx[m_slot]  <= (int'(inv_x) + SPR_W/2 + COL_PITCH*m_col) % 1024;
            my[m_slot]  <= (int'(inv_y) + ROW_PITCH*m_row + SPR_H) % 1024;
            mfire       <= 1'b1;
         end
         mlfsr <= (mlfsr >> 1) ^ (mlfsr[0] ? TAP_MASK : 16'h0000);
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [N_MSL*10-1:0] exp_x;
   logic [N_MSL*10-1:0] exp_y;
   logic [N_MSL-1:0]    exp_a;

   always @(negedge clk) begin
      for (int k = 0; k < N_MSL; k++) begin
         exp_x[10*k +: 10] = 10'(mx[k]);
         exp_y[10*k +: 10] = 10'(my[k]);
         exp_a[k]          = (mst[k] == S_FLY);
      end
      n_tests++;
      if (m_x !== exp_x || m_y !== exp_y || m_active !== exp_a || fire !== mfire) begin
         n_fail++;
         $display("FAIL cycle t=%0t got x=%h y=%h act=%b fire=%b want x=%h y=%h act=%b fire=%b",
                  $time, m_x, m_y, m_active, fire, exp_x, exp_y, exp_a, mfire);
      end
      if (fire === 1'b1) begin
         fire_seen++;
         $display("[TB] t=%0t launch active=%b m_x=%h m_y=%h", $time, m_active, m_x, m_y);
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_frame();
      tick();
      frame = 1'b1;
      tick();
      frame = 1'b0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b0; frame = 1'b0; enable = 1'b0; hit_valid = 1'b0; hit_idx = 3'd0;
      inv_x = 10'd100; inv_y = 10'd300; alive = '1;
      tick(); tick(); tick();
      check("reset_active", m_active, 0);
      check("reset_xy", m_x | m_y, 0);

      // First frame after release: seed column 5, bottom row 4.
      rst = 1'b1; enable = 1'b1; frame = 1'b1;
      tick();
      frame = 1'b0;
      check("launch_active", m_active, 3'b001);
      check("launch_fire", fire, 1);
      check("launch_x", m_x[9:0], 272);
      check("launch_y", m_y[9:0], 444);
      tick();
      check("fire_one_cycle", fire, 0);

      // Fly to 460, retire at the floor, then nine frames back to IDLE.
      enable = 1'b0;
      repeat (4) do_frame();
      check("y_460", m_y[9:0], 460);
      check("fly_460", m_active, 3'b001);
      do_frame();
      check("retire_active", m_active, 3'b000);
      check("retire_hold_y", m_y[9:0], 460);
      repeat (8) do_frame();
      enable = 1'b1;
      do_frame();
      check("cool_slot1_first", m_active, 3'b010);
      check("cool_fire", fire, 1);
      do_frame();
      check("cool_slot0_back", m_active, 3'b011);

      // Hit on slot 1 coincident with a frame move.
      rst = 1'b0; tick(); tick();
      inv_y = 10'd56; rst = 1'b1; frame = 1'b1;
      tick();
      frame = 1'b0;
      tick();
      frame = 1'b1;
      tick();
      frame = 1'b0;
      check("slot1_x_col1", m_x[19:10], 144);
      check("slot1_y", m_y[19:10], 200);
      check("slot0_y", m_y[9:0], 204);
      enable = 1'b0;
      tick();
      hit_valid = 1'b1; hit_idx = 3'd1; frame = 1'b1;
      tick();
      hit_valid = 1'b0; frame = 1'b0;
      check("hit_hold_y", m_y[19:10], 200);
      check("hit_active", m_active, 3'b001);
      check("hit_other_moves", m_y[9:0], 208);
      hit_valid = 1'b1; hit_idx = 3'd5; tick();
      hit_idx = 3'd1; tick();
      hit_idx = 3'd2; tick();
      hit_valid = 1'b0;
      check("hit_ignored", m_active, 3'b001);

      // Fill all slots, then a frame with no free slot.
      enable = 1'b1;
      do_frame();
      check("fill_slot2", m_active, 3'b101);
      repeat (9) do_frame();
      check("fill_all", m_active, 3'b111);
      check("fill_fire", fire, 1);
      do_frame();
      check("full_no_fire", fire, 0);
      check("full_active", m_active, 3'b111);

      // No live invaders: nothing launches.
      alive = '0;
      hit_valid = 1'b1; hit_idx = 3'd0; tick();
      hit_idx = 3'd1; tick();
      hit_idx = 3'd2; tick();
      hit_valid = 1'b0;
      check("all_hit", m_active, 3'b000);
      f0 = fire_seen;
      repeat (12) do_frame();
      check("dead_grid_fires", fire_seen - f0, 0);

      // Only row 1 alive, then 20 frames with launches disabled.
      for (int c = 0; c < INV_COLS; c++) alive[INV_COLS + c] = 1'b1;
      inv_y = 10'd20;
      do_frame();
      check("row1_active", m_active, 3'b001);
      check("row1_y", m_y[9:0], 68);
      enable = 1'b0; inv_y = 10'd200; inv_x = 10'd5; alive = '1;
      f0 = fire_seen;
      repeat (20) do_frame();
      check("disabled_y", m_y[9:0], 148);
      check("disabled_active", m_active, 3'b001);
      check("disabled_fires", fire_seen - f0, 0);

      // Asynchronous reset with two missiles up and fire high.
      enable = 1'b1;
      do_frame();
      check("pre_reset_active", m_active, 3'b011);
      check("pre_reset_fire", fire, 1);
      #1 rst = 1'b0;
      #1;
      check("async_active", m_active, 0);
      check("async_fire", fire, 0);
      check("async_x", m_x, 0);
      check("async_y", m_y, 0);
      tick(); tick();
      inv_x = 10'd100; inv_y = 10'd300; rst = 1'b1; frame = 1'b1;
      tick();
      frame = 1'b0;
      check("reseed_x", m_x[9:0], 272);
      check("reseed_y", m_y[9:0], 444);
      check("reseed_active", m_active, 3'b001);
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
